instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Responder end of the program-counter to instruction-memory interface. Takes the PC's instr_addr, returns the 32-bit instruction, and asserts stall so the PC holds while a fetch is outstanding. Fetches over a valid/ready request and valid response memory bus. Keeps a one-entry last-fetch buffer so that a re-presented address, such as a held PC, hits without a bus transaction. Includes a response watchdog.

Parameters:
- TIMEOUT_CYCLES, 64: max cycles in WAIT before fetch_error; counter width is clog2(TIMEOUT_CYCLES+1).
- NOP_INSTR, 32'h0000_0013: instruction driven on error, flush or misalign (addi x0,x0,0).

Ports:
- clk  input  1  core clock; all state updates on posedge clk.
- reset  input  1  synchronous, active-high reset, sampled on posedge clk.
- instr_addr  input  32  byte address from the program counter.
- flush  input  1  discard any outstanding fetch and invalidate the buffer.
- instr  output  32  fetched instruction.
- instr_valid  output  1  instr corresponds to the current instr_addr.
- stall  output  1  PC must hold next_pc (= !instr_valid).
- fetch_error  output  1  one-cycle pulse on watchdog expiry.
- mem_req_valid  output  1  bus request valid.
- mem_req_ready  input  1  bus accepts request.
- mem_req_addr  output  32  word-aligned request address ({addr[31:2],2'b00}).
- mem_resp_valid  input  1  response data valid.
- mem_resp_data  input  32  response instruction word.

Behaviour:
- Reset (synchronous, active-high) clears the following:
  - state=IDLE, buf_valid=0, buf_tag=0, buf_data=0, drop=0, timeout count=0.
  - Outputs: mem_req_valid=0, fetch_error=0, instr_valid=0, instr=NOP_INSTR, stall=1.
  - Reset asserted mid-fetch abandons the transaction. A late mem_resp_valid after reset is ignored, because state is IDLE.
- Hit: buf_valid && buf_tag==instr_addr[31:2].
  - instr=buf_data and instr_valid=1 combinationally, same cycle. Zero-latency hit.
- States:
  - IDLE: on a miss with flush=0, latch req_addr={instr_addr[31:2],2'b00} and go to REQ. On a hit, stay.
  - REQ: mem_req_valid=1, mem_req_addr=req_addr (held stable until accepted). When mem_req_valid&&mem_req_ready, go to WAIT and clear the counter.
  - WAIT: increment the counter each cycle.
    - mem_resp_valid with drop=0: buf_tag=req_addr[31:2], buf_data=mem_resp_data, buf_valid=1, go to IDLE. The next cycle hits, so miss latency is 2 cycles plus bus latency.
    - mem_resp_valid with drop=1: discard the data, clear drop, go to IDLE.
    - Counter reaching TIMEOUT_CYCLES before a response: pulse fetch_error for 1 cycle, buf_valid=0, go to IDLE. A response arriving later in IDLE or REQ is ignored.
- flush:
  - In IDLE: buf_valid=0 next cycle. Suppresses a new request that cycle.
  - In REQ: withdraw the request, go to IDLE. If ready is sampled high in the same cycle, the handshake completes and flush is treated as it is in WAIT.
  - In WAIT: set drop=1 and remain in WAIT until the response or timeout.
  - Flush and mem_resp_valid in the same WAIT cycle: the response is dropped and the buffer is not filled.
  - While flush=1, instr_valid=0.
- instr_addr changing while stalled is legal. On return to IDLE the new address is compared, and a mismatch triggers another fetch.
- Only one transaction is ever outstanding.
- Address bits [1:0] never reach the bus.

Optional Feature:
ALIGN_CHECK_EN
- Defined:
  - Adds output misaligned (1 bit) = (instr_addr[1:0]!=0) in IDLE.
  - When misaligned=1: no request is issued; instr=NOP_INSTR and instr_valid=1 so the core can advance to a trap handler.
- Undefined:
  - The port is absent and bits [1:0] are ignored. An address ...01 hits or fetches the same word as ...00.

Decomposition:
- Shared package rv_core_pkg:
  - fetch_state_t enum {IDLE, REQ, WAIT}.
  - XLEN=32, NOP_INSTR constant, WORD_ADDR_W=30.
- One sub-module: fetch_line_buffer (tag/data/valid registers plus hit compare, with fill and invalidate inputs).
- FSM and watchdog stay in the top level.

Test Plan:
- Cold miss: reset, instr_addr=0x0000_0010, ready=1, response 3 cycles later with 0x0050_0093:
  - exactly one request to 0x10;
  - stall=1 until the cycle after the response;
  - then instr=0x0050_0093 with instr_valid=1, and no further requests while the address is held.
- Backpressure: mem_req_ready=0 for 5 cycles:
  - mem_req_valid=1 and mem_req_addr stable for all 5 cycles;
  - handshake on the 6th cycle, then normal completion.
- Flush in WAIT: flush pulsed 1 cycle after acceptance, response 0xDEAD_BEEF:
  - the response is discarded and buf_valid=0;
  - a fresh request is issued for the current instr_addr.
- Timeout: TIMEOUT_CYCLES=8, no response:
  - fetch_error pulses exactly once, 8 cycles after acceptance;
  - returns to IDLE; a late response 4 cycles later is ignored.
- Reset mid-WAIT:
  - all outputs return to reset values;
  - buffer invalid; the next fetch operates normally.
- ALIGN_CHECK_EN, instr_addr=0x0000_0006:
  - misaligned=1, instr=0x0000_0013, instr_valid=1, no bus request.
- Without ALIGN_CHECK_EN, same address 0x0000_0006: fetches word 0x4 on the bus.

Source files
------------

// File: rtl/rv_core_pkg.sv
// ---------------------------------------------------------------------------
// rv_core_pkg
// Shared types and constants for the instruction fetch path.
//   XLEN          : datapath / address width
//   WORD_ADDR_W   : width of a 32-bit-word address (byte address bits [31:2])
//   NOP_INSTR     : addi x0,x0,0, driven when no real instruction is available
//   fetch_state_t : fetch FSM states
// ---------------------------------------------------------------------------
package rv_core_pkg;

   localparam int XLEN        = 32;
   localparam int WORD_ADDR_W = 30;

   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } fetch_state_t;

   // Word index of a byte address; the two low bits select a byte in the word.
   function automatic logic [WORD_ADDR_W-1:0] word_addr(input logic [XLEN-1:0] byte_addr);
      return byte_addr[XLEN-1:2];
   endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit_if
// Instruction memory bus: valid/ready request channel, valid-only response.
//   mem_req_valid  : request valid (master -> slave)
//   mem_req_ready  : request accepted (slave -> master)
//   mem_req_addr   : word-aligned byte address (master -> slave)
//   mem_resp_valid : response data valid (slave -> master)
//   mem_resp_data  : instruction word (slave -> master)
// Modports: master = fetch unit, slave = memory.
// ---------------------------------------------------------------------------
interface instr_fetch_unit_if;
   import rv_core_pkg::*;

   logic            mem_req_valid;
   logic            mem_req_ready;
   logic [XLEN-1:0] mem_req_addr;
   logic            mem_resp_valid;
   logic [XLEN-1:0] mem_resp_data;

   modport master (
      output mem_req_valid,
      output mem_req_addr,
      input  mem_req_ready,
      input  mem_resp_valid,
      input  mem_resp_data
   );

   modport slave (
      input  mem_req_valid,
      input  mem_req_addr,
      output mem_req_ready,
      output mem_resp_valid,
      output mem_resp_data
   );

endinterface

// File: rtl/fetch_line_buffer.sv
// ---------------------------------------------------------------------------
// fetch_line_buffer
// One-entry last-fetch buffer: tag, data and valid registers plus hit compare.
//   clk, reset  : clock, synchronous active-high reset
//   fill_en     : load fill_tag/fill_data and mark valid
//   fill_tag    : word address of the filled instruction
//   fill_data   : filled instruction word
//   inval_en    : clear valid (wins over fill_en)
//   lookup_tag  : word address being looked up
//   hit         : buffer valid and tag matches lookup_tag
//   hit_data    : buffered instruction word
// ---------------------------------------------------------------------------
module fetch_line_buffer
   import rv_core_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   fill_en,
   input  logic [WORD_ADDR_W-1:0] fill_tag,
   input  logic [XLEN-1:0]        fill_data,
   input  logic                   inval_en,
   input  logic [WORD_ADDR_W-1:0] lookup_tag,
   output logic                   hit,
   output logic [XLEN-1:0]        hit_data
);

   logic                   buf_valid_q, buf_valid_d;
   logic [WORD_ADDR_W-1:0] buf_tag_q,   buf_tag_d;
   logic [XLEN-1:0]        buf_data_q,  buf_data_d;

   // Next-state of the buffer entry: invalidate, fill, or hold.
   always_comb begin
      buf_valid_d = buf_valid_q;
      buf_tag_d   = buf_tag_q;
      buf_data_d  = buf_data_q;
      if (inval_en) begin
         buf_valid_d = 1'b0;
      end else if (fill_en) begin
         buf_valid_d = 1'b1;
         buf_tag_d   = fill_tag;
         buf_data_d  = fill_data;
      end else begin
         buf_valid_d = buf_valid_q;
      end
   end

   // Buffer entry registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         buf_valid_q <= 1'b0;
         buf_tag_q   <= {WORD_ADDR_W{1'b0}};
         buf_data_q  <= {XLEN{1'b0}};
      end else begin
         buf_valid_q <= buf_valid_d;
         buf_tag_q   <= buf_tag_d;
         buf_data_q  <= buf_data_d;
      end
   end

   assign hit      = buf_valid_q && (buf_tag_q == lookup_tag);
   assign hit_data = buf_data_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
// Responder between the program counter and instruction memory. Returns the
// instruction for instr_addr, stalling the PC while a fetch is outstanding.
// A one-entry buffer gives zero-latency hits on a re-presented address; a
// watchdog abandons a fetch whose response never arrives.
//
// Parameters:
//   TIMEOUT_CYCLES : WAIT cycles allowed before fetch_error
//   NOP_INSTR      : instruction driven when nothing valid is available
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   instr_addr     : byte address from the PC
//   flush          : drop outstanding fetch, invalidate buffer
//   instr          : instruction for instr_addr
//   instr_valid    : instr belongs to the current instr_addr
//   stall          : !instr_valid, PC holds
//   fetch_error    : one-cycle pulse on watchdog expiry
//   misaligned     : (ALIGN_CHECK_EN only) instr_addr[1:0]!=0 while IDLE
//   mem_if         : memory bus, master side
// Build option: define ALIGN_CHECK_EN to add the misaligned port and to answer
// misaligned addresses with a NOP instead of fetching.
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
   parameter int                               TIMEOUT_CYCLES = 64,
   parameter logic [rv_core_pkg::XLEN-1:0]     NOP_INSTR      = rv_core_pkg::NOP_INSTR
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [rv_core_pkg::XLEN-1:0] instr_addr,
   input  logic                         flush,
   output logic [rv_core_pkg::XLEN-1:0] instr,
   output logic                         instr_valid,
   output logic                         stall,
   output logic                         fetch_error,
`ifdef ALIGN_CHECK_EN
   output logic                         misaligned,
`endif
   instr_fetch_unit_if.master           mem_if
);
   import rv_core_pkg::*;

   localparam int              CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

   fetch_state_t           state_q, state_d;
   logic [WORD_ADDR_W-1:0] req_addr_q, req_addr_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   drop_q, drop_d;
   logic                   fetch_error_q, fetch_error_d;

   logic                   buf_hit_s;
   logic [XLEN-1:0]        buf_data_s;
   logic                   fill_en_s;
   logic                   inval_en_s;
   logic                   misalign_s;
   logic                   hit_s;
   logic                   handshake_s;
   logic [CNT_W-1:0]       cnt_inc_s;

`ifdef ALIGN_CHECK_EN
   assign misalign_s = (instr_addr[1:0] != 2'b00);
   assign misaligned = (state_q == IDLE) && misalign_s;
`else
   // Byte offset is ignored: ...01 maps onto the same word as ...00.
   logic unused_addr_lsb_s;
   assign unused_addr_lsb_s = ^instr_addr[1:0];
   assign misalign_s        = 1'b0;
`endif

   fetch_line_buffer u_line_buf (
      .clk        (clk),
      .reset      (reset),
      .fill_en    (fill_en_s),
      .fill_tag   (req_addr_q),
      .fill_data  (mem_if.mem_resp_data),
      .inval_en   (inval_en_s),
      .lookup_tag (word_addr(instr_addr)),
      .hit        (buf_hit_s),
      .hit_data   (buf_data_s)
   );

   // A misaligned address never returns a buffered word.
   assign hit_s       = buf_hit_s && !misalign_s;
   assign handshake_s = (state_q == REQ) && mem_if.mem_req_ready;
   assign cnt_inc_s   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

   assign mem_if.mem_req_valid = (state_q == REQ);
   assign mem_if.mem_req_addr  = {req_addr_q, 2'b00};
   assign fetch_error          = fetch_error_q;
   assign stall                = !instr_valid;

   // Instruction output: flush masks everything, misalign answers NOP, else hit.
   always_comb begin
      instr_valid = 1'b0;
      instr       = NOP_INSTR;
      if (flush) begin
         instr_valid = 1'b0;
         instr       = NOP_INSTR;
      end else if (misalign_s && (state_q == IDLE)) begin
         instr_valid = 1'b1;
         instr       = NOP_INSTR;
      end else if (hit_s) begin
         instr_valid = 1'b1;
         instr       = buf_data_s;
      end else begin
         instr_valid = 1'b0;
         instr       = NOP_INSTR;
      end
   end

   // Fetch FSM next-state, watchdog and buffer control.
   always_comb begin
      state_d       = state_q;
      req_addr_d    = req_addr_q;
      cnt_d         = cnt_q;
      drop_d        = drop_q;
      fetch_error_d = 1'b0;
      fill_en_s     = 1'b0;
      inval_en_s    = flush;
      case (state_q)
         IDLE: begin
            if (!flush && !hit_s && !misalign_s) begin
               req_addr_d = word_addr(instr_addr);
               state_d    = REQ;
            end else begin
               state_d    = IDLE;
            end
         end
         REQ: begin
            if (handshake_s) begin
               // A flush coinciding with acceptance still completes the
               // handshake; the response is then discarded.
               state_d = WAIT;
               cnt_d   = {CNT_W{1'b0}};
               drop_d  = flush;
            end else if (flush) begin
               state_d = IDLE;
            end else begin
               state_d = REQ;
            end
         end
         WAIT: begin
            cnt_d = cnt_inc_s;
            if (mem_if.mem_resp_valid) begin
               // A flush in the response cycle also drops the data.
               fill_en_s = !drop_q && !flush;
               drop_d    = 1'b0;
               state_d   = IDLE;
            end else if (cnt_inc_s == CNT_LIMIT) begin
               fetch_error_d = 1'b1;
               inval_en_s    = 1'b1;
               drop_d        = 1'b0;
               state_d       = IDLE;
            end else begin
               drop_d  = drop_q | flush;
               state_d = WAIT;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // FSM, request address, watchdog and error pulse registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         req_addr_q    <= {WORD_ADDR_W{1'b0}};
         cnt_q         <= {CNT_W{1'b0}};
         drop_q        <= 1'b0;
         fetch_error_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         req_addr_q    <= req_addr_d;
         cnt_q         <= cnt_d;
         drop_q        <= drop_d;
         fetch_error_q <= fetch_error_d;
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
// Directed scenarios followed by a randomized phase. The reference model is a
// word-addressed memory image plus protocol rules: any valid instruction must
// equal the memory word (or NOP for a checked misaligned address), requests
// hold while not accepted, one transaction at a time, stall == !instr_valid.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;
   import rv_core_pkg::*;

   localparam int          TMO = 8;
   localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef ALIGN_CHECK_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic [31:0] instr_addr;
   logic [31:0] instr;
   logic        instr_valid;
   logic        stall;
   logic        fetch_error;
`ifdef ALIGN_CHECK_EN
   logic        misaligned;
`endif

   instr_fetch_unit_if bus_if ();

   instr_fetch_unit #(.TIMEOUT_CYCLES(TMO), .NOP_INSTR(NOP)) dut (
      .clk         (clk),
      .reset       (reset),
      .instr_addr  (instr_addr),
      .flush       (flush),
      .instr       (instr),
      .instr_valid (instr_valid),
      .stall       (stall),
      .fetch_error (fetch_error),
`ifdef ALIGN_CHECK_EN
      .misaligned  (misaligned),
`endif
      .mem_if      (bus_if.master)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic [31:0] mem_model [logic [29:0]];

   // memory responder state
   bit          pend = 1'b0;
   int          pend_cnt = 0;
   logic [29:0] pend_word = 30'd0;
   int          g_lat = 0;
   bit          g_noresp = 1'b0;
   bit          g_ovr_en = 1'b0;
   logic [31:0] g_ovr_data = 32'd0;
   bit          g_late = 1'b0;

   // observations
   int          req_count = 0;
   logic [31:0] last_req_addr = 32'd0;
   int          hs_cyc = -1;
   int          resp_cyc = -1;
   int          first_valid_cyc = -1;
   int          ferr_count = 0;
   int          ferr_cyc = -1;
   int          stall_run = 0;
   int          max_run = 0;
   bit          prev_hold = 1'b0;
   logic [31:0] prev_addr = 32'd0;
   logic        s_req_valid, s_ivalid, s_stall, s_ferr;
   logic [31:0] s_req_addr, s_instr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mem_rd(input logic [29:0] w);
      if (mem_model.exists(w)) return mem_model[w];
      return ({2'b00, w} * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic logic [31:0] exp_instr(input logic [31:0] a);
      if (ALIGN && (a[1:0] != 2'b00)) return NOP;
      return mem_rd(a[31:2]);
   endfunction

   // One clock cycle: memory responds, outputs are sampled and checked
   // against the model, a handshake is recorded, then the edge passes.
   task automatic cycle();
      cyc++;
      if (pend && pend_cnt == 0) begin
         bus_if.mem_resp_valid = 1'b1;
         bus_if.mem_resp_data  = g_ovr_en ? g_ovr_data : mem_rd(pend_word);
         g_ovr_en = 1'b0;
         pend     = 1'b0;
         resp_cyc = cyc;
      end else begin
         bus_if.mem_resp_valid = g_late;
         bus_if.mem_resp_data  = $urandom();
         g_late = 1'b0;
         if (pend) pend_cnt--;
      end
      #1;
      s_req_valid = bus_if.mem_req_valid;
      s_req_addr  = bus_if.mem_req_addr;
      s_instr     = instr;
      s_ivalid    = instr_valid;
      s_stall     = stall;
      s_ferr      = fetch_error;
      chk("stall_vs_valid", 32'(s_stall), 32'(!s_ivalid));
      if (flush) chk("valid_under_flush", 32'(s_ivalid), 32'd0);
      if (s_ivalid) chk("instr_data", s_instr, exp_instr(instr_addr));
      if (s_req_valid) chk("req_word_aligned", 32'(s_req_addr[1:0]), 32'd0);
      if (prev_hold) begin
         chk("req_hold_valid", 32'(s_req_valid), 32'd1);
         chk("req_hold_addr", s_req_addr, prev_addr);
      end
      if (s_ferr) begin
         ferr_count++;
         ferr_cyc = cyc;
      end
      if (s_ivalid && first_valid_cyc < 0) first_valid_cyc = cyc;
      stall_run = s_stall ? stall_run + 1 : 0;
      if (stall_run > max_run) max_run = stall_run;
      prev_hold = s_req_valid && !bus_if.mem_req_ready && !flush && !reset;
      prev_addr = s_req_addr;
      if (s_req_valid && bus_if.mem_req_ready && !reset) begin
         chk("single_outstanding", 32'(pend), 32'd0);
         req_count++;
         last_req_addr = s_req_addr;
         hs_cyc = cyc;
         if (!g_noresp) begin
            pend      = 1'b1;
            pend_cnt  = g_lat;
            pend_word = s_req_addr[31:2];
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input string tag, input int limit);
      int n = 0;
      first_valid_cyc = -1;
      while (first_valid_cyc < 0 && n < limit) begin
         cycle();
         n++;
      end
      chk({tag, "_reached_valid"}, 32'(first_valid_cyc >= 0), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      int rc0;
      int acc;
      int n;
      reset = 1'b1;
      flush = 1'b0;
      instr_addr = 32'h0000_0010;
      bus_if.mem_req_ready  = 1'b0;
      bus_if.mem_resp_valid = 1'b0;
      bus_if.mem_resp_data  = 32'd0;
      @(posedge clk);
      #1;
      cycle();
      cycle();
      chk("rst_req_valid", 32'(s_req_valid), 32'd0);
      chk("rst_fetch_error", 32'(s_ferr), 32'd0);
      chk("rst_instr_valid", 32'(s_ivalid), 32'd0);
      chk("rst_instr", s_instr, NOP);
      chk("rst_stall", 32'(s_stall), 32'd1);

      // cold miss, response three cycles after acceptance
      mem_model[30'h4] = 32'h0050_0093;
      reset = 1'b0;
      bus_if.mem_req_ready = 1'b1;
      g_lat = 2;
      rc0 = req_count;
      wait_valid("cold", 20);
      chk("cold_req_count", 32'(req_count - rc0), 32'd1);
      chk("cold_req_addr", last_req_addr, 32'h0000_0010);
      chk("cold_resp_gap", 32'(resp_cyc - hs_cyc), 32'd3);
      chk("cold_valid_after_resp", 32'(first_valid_cyc), 32'(resp_cyc + 1));
      chk("cold_instr", s_instr, 32'h0050_0093);
      repeat (5) cycle();
      chk("cold_no_rerequest", 32'(req_count - rc0), 32'd1);
      chk("cold_hold_valid", 32'(s_ivalid), 32'd1);

      // backpressure: five refused cycles, accepted on the sixth
      instr_addr = 32'h0000_0100;
      bus_if.mem_req_ready = 1'b0;
      g_lat = 1;
      rc0 = req_count;
      cycle();
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("bp_valid", 32'(s_req_valid), 32'd1);
         chk("bp_addr", s_req_addr, 32'h0000_0100);
      end
      chk("bp_no_handshake", 32'(req_count - rc0), 32'd0);
      bus_if.mem_req_ready = 1'b1;
      cycle();
      chk("bp_handshake_6th", 32'(req_count - rc0), 32'd1);
      wait_valid("bp", 20);
      chk("bp_instr", s_instr, mem_rd(30'h40));

      // flush one cycle after acceptance; DEADBEEF response must vanish
      instr_addr = 32'h0000_0200;
      g_lat = 3;
      g_ovr_en = 1'b1;
      g_ovr_data = 32'hDEAD_BEEF;
      rc0 = req_count;
      cycle();
      cycle();
      chk("fw_accepted", 32'(req_count - rc0), 32'd1);
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      wait_valid("fw", 40);
      chk("fw_reissued", 32'(req_count - rc0), 32'd2);
      chk("fw_addr", last_req_addr, 32'h0000_0200);
      chk("fw_instr", s_instr, mem_rd(30'h80));

      // flush while hitting in IDLE invalidates the buffer
      flush = 1'b1;
      cycle();
      chk("fi_valid_low", 32'(s_ivalid), 32'd0);
      flush = 1'b0;
      rc0 = req_count;
      cycle();
      chk("fi_buffer_invalid", 32'(s_ivalid), 32'd0);
      wait_valid("fi", 20);
      chk("fi_refetch", 32'(req_count - rc0), 32'd1);

      // watchdog: no response ever arrives
      instr_addr = 32'h0000_0300;
      g_noresp = 1'b1;
      ferr_count = 0;
      rc0 = req_count;
      cycle();
      cycle();
      chk("to_accepted", 32'(req_count - rc0), 32'd1);
      acc = hs_cyc;
      n = 0;
      while (ferr_count == 0 && n < 20) begin
         cycle();
         n++;
      end
      // eight WAIT cycles follow the acceptance cycle; the pulse shows next
      chk("to_pulse_time", 32'(ferr_cyc), 32'(acc + TMO + 1));
      bus_if.mem_req_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (i == 3) g_late = 1'b1;
         cycle();
      end
      chk("to_single_pulse", 32'(ferr_count), 32'd1);
      chk("to_late_ignored", 32'(s_ivalid), 32'd0);
      chk("to_retry_pending", 32'(s_req_valid), 32'd1);
      g_noresp = 1'b0;
      g_lat = 1;
      bus_if.mem_req_ready = 1'b1;
      wait_valid("to_recover", 20);
      chk("to_recover_instr", s_instr, mem_rd(30'hC0));

      // reset in the middle of WAIT
      instr_addr = 32'h0000_0400;
      g_lat = 6;
      cycle();
      cycle();
      cycle();
      reset = 1'b1;
      pend = 1'b0;
      instr_addr = 32'h0000_0300;
      cycle();
      cycle();
      chk("rw_req_valid", 32'(s_req_valid), 32'd0);
      chk("rw_fetch_error", 32'(s_ferr), 32'd0);
      chk("rw_buffer_invalid", 32'(s_ivalid), 32'd0);
      chk("rw_instr", s_instr, NOP);
      chk("rw_stall", 32'(s_stall), 32'd1);
      reset = 1'b0;
      g_late = 1'b1;
      g_lat = 2;
      rc0 = req_count;
      wait_valid("rw", 20);
      chk("rw_one_request", 32'(req_count - rc0), 32'd1);
      chk("rw_req_addr", last_req_addr, 32'h0000_0300);
      chk("rw_instr_after", s_instr, mem_rd(30'hC0));

      // byte offset 2 within word 1
      instr_addr = 32'h0000_0006;
      g_lat = 0;
      rc0 = req_count;
`ifdef ALIGN_CHECK_EN
      cycle();
      cycle();
      chk("mis_flag", 32'(misaligned), 32'd1);
      chk("mis_instr", s_instr, NOP);
      chk("mis_valid", 32'(s_ivalid), 32'd1);
      chk("mis_no_request", 32'(req_count - rc0), 32'd0);
`else
      wait_valid("off6", 20);
      chk("off6_req_addr", last_req_addr, 32'h0000_0004);
      chk("off6_instr", s_instr, mem_rd(30'h1));
      instr_addr = 32'h0000_0005;
      cycle();
      chk("off5_hit", 32'(s_ivalid), 32'd1);
      chk("off5_no_request", 32'(req_count - rc0), 32'd1);
`endif

      // randomized traffic over a small working set
      ferr_count = 0;
      stall_run = 0;
      max_run = 0;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            logic [1:0] low;
            if (ALIGN) low = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            else       low = 2'($urandom_range(0, 3));
            instr_addr = (32'($urandom_range(0, 7)) << 2) | 32'(low);
         end
         flush = ($urandom_range(0, 15) == 0);
         bus_if.mem_req_ready = 1'($urandom_range(0, 1));
         g_lat = $urandom_range(0, 4);
         cycle();
      end
      flush = 1'b0;
      chk("rand_no_fetch_error", 32'(ferr_count), 32'd0);
      chk("rand_liveness", 32'(max_run <= 60), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
